// File: rtl/btb_assoc_pkg.sv
// Common types, address-split constants and width helpers for the BTB.
package btb_assoc_pkg;

  `include "sys_defs.svh"

  // Instruction PCs are word aligned, so the two lowest bits carry no index.
  localparam int unsigned PC_OFS = 2;

  function automatic int unsigned log2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btb_repl.sv
// Per-set replacement state and victim selection for btb_assoc.
// BTB_PLRU_EN selects tree pseudo-LRU; otherwise a per-set round-robin counter.
`include "sys_defs.svh"

module btb_repl
  import btb_assoc_pkg::*;
#(
  parameter  int unsigned SETS  = `BTB_SETS,
  parameter  int unsigned WAYS  = `BTB_WAYS,
  localparam int unsigned SET_W = log2_min1(SETS),
  localparam int unsigned WAY_W = log2_min1(WAYS)
) (
  input  logic             clock,
  input  logic             reset,
`ifdef BTB_PLRU_EN
  input  logic             qry_touch_i,
  input  logic [SET_W-1:0] qry_set_i,
  input  logic [WAY_W-1:0] qry_way_i,
  input  logic             wr_touch_i,
  input  logic [WAY_W-1:0] wr_way_i,
`else
  input  logic             wr_alloc_i,
`endif
  input  logic [SET_W-1:0] wr_set_i,
  output logic [WAY_W-1:0] victim_o
);

  if (WAYS == 1) begin : g_direct
    assign victim_o = '0;
  end else begin : g_assoc
`ifdef BTB_PLRU_EN
    // Heap-ordered tree, node i has children 2i+1 and 2i+2. The root decides
    // way bit 0, deeper levels decide higher bits; a node bit names the side
    // holding the victim.
    localparam int unsigned NODES = WAYS - 1;

    logic [NODES-1:0] tree_q [SETS];
    logic [NODES-1:0] tree_d [SETS];

    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] t,
                                                    input logic [WAY_W-1:0] way);
      logic [NODES-1:0] r;
      logic [WAY_W-1:0] node;
      r    = t;
      node = '0;
      for (int k = 0; k < WAY_W; k++) begin
        r[node] = ~way[k];
        node    = WAY_W'(2 * node + 1 + way[k]);
      end
      return r;
    endfunction

    // The write touch follows the query touch so a same-set write wins.
    always_comb begin
      tree_d = tree_q;
      if (qry_touch_i) tree_d[qry_set_i] = plru_touch(tree_d[qry_set_i], qry_way_i);
      if (wr_touch_i)  tree_d[wr_set_i]  = plru_touch(tree_d[wr_set_i], wr_way_i);
    end

    always_comb begin
      logic [WAY_W-1:0] node;
      node     = '0;
      victim_o = '0;
      for (int k = 0; k < WAY_W; k++) begin
        victim_o[k] = tree_q[wr_set_i][node];
        node        = WAY_W'(2 * node + 1 + victim_o[k]);
      end
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
      end else begin
        tree_q <= tree_d;
      end
    end
`else
    logic [WAY_W-1:0] rr_q [SETS];
    logic [WAY_W-1:0] rr_d [SETS];

    // Only an allocation into a full set advances the pointer.
    always_comb begin
      rr_d = rr_q;
      if (wr_alloc_i) rr_d[wr_set_i] = rr_q[wr_set_i] + 1'b1;
    end

    assign victim_o = rr_q[wr_set_i];

    always_ff @(posedge clock) begin
      if (!reset) begin
        for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else begin
        rr_q <= rr_d;
      end
    end
`endif
  end

endmodule

// File: rtl/sys_defs.svh
// Shared BTB configuration macros and the stored entry layout.
// The entry typedef is pulled into btb_assoc_pkg; the macros stay global.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`ifndef XLEN
`define XLEN 32
`endif
`ifndef BTB_SETS
`define BTB_SETS 16
`endif
`ifndef BTB_WAYS
`define BTB_WAYS 4
`endif
`ifndef BTB_TAG_BITS
`define BTB_TAG_BITS 10
`endif

typedef struct packed {
  logic                     valid;
  logic [`BTB_TAG_BITS-1:0] tag;
  logic [`XLEN-1:0]         target;
} BTB_ENTRY;

`endif

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with a registered one-cycle lookup.
// Define BTB_PLRU_EN for tree pseudo-LRU replacement; round-robin otherwise.
`include "sys_defs.svh"

module btb_assoc
  import btb_assoc_pkg::*;
#(
  parameter int unsigned SETS     = `BTB_SETS,
  parameter int unsigned WAYS     = `BTB_WAYS,
  parameter int unsigned TAG_BITS = `BTB_TAG_BITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             write_enable,
  input  logic [`XLEN-1:0] write_source_pc,
  input  logic [`XLEN-1:0] write_dest_pc,
  input  logic             query_valid,
  input  logic [`XLEN-1:0] query_pc,
  output logic             hit,
  output logic [`XLEN-1:0] target_pc
);

  localparam int unsigned SET_W   = log2_min1(SETS);
  localparam int unsigned WAY_W   = log2_min1(WAYS);
  localparam int unsigned TAG_LSB = PC_OFS + SET_W;

  BTB_ENTRY entries_q [SETS][WAYS];

  logic [SET_W-1:0]    q_set, w_set;
  logic [TAG_BITS-1:0] q_tag, w_tag;
  logic [WAYS-1:0]     q_match, w_match, w_valid;
  logic [WAY_W-1:0]    q_way, w_hit_way, w_free_way, w_way, victim;
  logic                q_fire, wr_fire, w_present, w_full;
  logic                hit_d, hit_q;
  logic [`XLEN-1:0]    target_d, target_q;
  logic                unused_pc_bits;

  assign q_set = query_pc[PC_OFS +: SET_W];
  assign q_tag = query_pc[TAG_LSB +: TAG_BITS];
  assign w_set = write_source_pc[PC_OFS +: SET_W];
  assign w_tag = write_source_pc[TAG_LSB +: TAG_BITS];

  assign unused_pc_bits = ^{query_pc[PC_OFS-1:0], query_pc[`XLEN-1:TAG_LSB+TAG_BITS],
                            write_source_pc[PC_OFS-1:0],
                            write_source_pc[`XLEN-1:TAG_LSB+TAG_BITS]};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    q_match = '0;
    w_match = '0;
    w_valid = '0;
    for (int w = 0; w < WAYS; w++) begin
      q_match[w] = entries_q[q_set][w].valid && (entries_q[q_set][w].tag == q_tag);
      w_valid[w] = entries_q[w_set][w].valid;
      w_match[w] = w_valid[w] && (entries_q[w_set][w].tag == w_tag);
    end
  end

  // Scanning downwards leaves the lowest-numbered qualifying way selected.
  always_comb begin
    q_way      = '0;
    w_hit_way  = '0;
    w_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (q_match[w])  q_way      = WAY_W'(w);
      if (w_match[w])  w_hit_way  = WAY_W'(w);
      if (!w_valid[w]) w_free_way = WAY_W'(w);
    end
  end

  assign w_present = |w_match;
  assign w_full    = &w_valid;
  assign q_fire    = query_valid && !flush;
  assign wr_fire   = write_enable && !flush;

  always_comb begin
    w_way = victim;
    if (w_present)   w_way = w_hit_way;
    else if (!w_full) w_way = w_free_way;
  end

  // Lookups read pre-write contents; a flushed query reports a plain miss.
  always_comb begin
    hit_d    = q_fire && (|q_match);
    target_d = target_q;
    if (query_valid) target_d = hit_d ? entries_q[q_set][q_way].target : '0;
  end

  btb_repl #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_repl (
    .clock       (clock),
    .reset       (reset),
`ifdef BTB_PLRU_EN
    .qry_touch_i (hit_d),
    .qry_set_i   (q_set),
    .qry_way_i   (q_way),
    .wr_touch_i  (wr_fire),
    .wr_way_i    (w_way),
`else
    .wr_alloc_i  (wr_fire && !w_present && w_full),
`endif
    .wr_set_i    (w_set),
    .victim_o    (victim)
  );

  // NOTE: only the valid bits are reset; tags and targets are never read
  // while their valid bit is clear, so they can stay plain storage.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hit_q    <= 1'b0;
      target_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) entries_q[s][w].valid <= 1'b0;
    end else begin
      hit_q    <= hit_d;
      target_q <= target_d;
      if (flush) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) entries_q[s][w].valid <= 1'b0;
      end else if (wr_fire) begin
        entries_q[w_set][w_way] <= '{valid: 1'b1, tag: w_tag, target: write_dest_pc};
      end
    end
  end

  assign hit       = hit_q;
  assign target_pc = target_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: expectations are queued at drive time
// and compared against the registered outputs one edge later.
module tb_btb_assoc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] write_source_pc = '0;
  logic [31:0] write_dest_pc = '0;
  logic        query_valid = 1'b0;
  logic [31:0] query_pc = '0;
  logic        hit;
  logic [31:0] target_pc;

  btb_assoc dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .write_enable    (write_enable),
    .write_source_pc (write_source_pc),
    .write_dest_pc   (write_dest_pc),
    .query_valid     (query_valid),
    .query_pc        (query_pc),
    .hit             (hit),
    .target_pc       (target_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic        hit;
    logic [31:0] target;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_tgt = '0;

  localparam logic [31:0] PC_A = 32'h0040, PC_B = 32'h0080, PC_C = 32'h00C0;
  localparam logic [31:0] PC_D = 32'h0100, PC_E = 32'h0140, PC_F = 32'h0180;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: queue the expectation, let the edge happen, compare, idle inputs.
  task automatic step(input string tag, input logic eh, input logic [31:0] et);
    exp_t e;
    sb_q.push_back('{tag: tag, hit: eh, target: et});
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".hit"}, 32'(hit), 32'(e.hit));
    check({e.tag, ".tgt"}, target_pc, e.target);
    reset        = 1'b1;
    flush        = 1'b0;
    write_enable = 1'b0;
    query_valid  = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_query(input string tag, input logic [31:0] pc,
                          input logic eh, input logic [31:0] et);
    query_valid = 1'b1;
    query_pc    = pc;
    step(tag, eh, et);
    last_tgt = et;
  endtask

  task automatic do_write(input string tag, input logic [31:0] pc, input logic [31:0] dst);
    write_enable    = 1'b1;
    write_source_pc = pc;
    write_dest_pc   = dst;
    step(tag, 1'b0, last_tgt);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    step(tag, 1'b0, 32'h0);
    last_tgt = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clock);
    do_reset("rst0");
    query_valid = 1'b1;
    query_pc    = 32'h1040;
    do_reset("rst_q");

    for (int i = 0; i < 16; i++) do_query($sformatf("empty%0d", i), 32'(i) << 2, 1'b0, 32'h0);

    do_write("w1040", 32'h1040, 32'h2000);
    do_query("q1040", 32'h1040, 1'b1, 32'h2000);
    do_query("q1044", 32'h1044, 1'b0, 32'h0);
    do_query("q1040b", 32'h1040, 1'b1, 32'h2000);
    step("hold", 1'b0, 32'h2000);

    do_write("w1040u", 32'h1040, 32'h3000);
    do_query("q1040u", 32'h1040, 1'b1, 32'h3000);
    do_write("w2040", 32'h2040, 32'h4000);
    do_write("w3040", 32'h3040, 32'h5000);
    do_write("w4040", 32'h4040, 32'h6000);
    do_query("s0_1040", 32'h1040, 1'b1, 32'h3000);
    do_query("s0_2040", 32'h2040, 1'b1, 32'h4000);
    do_query("s0_3040", 32'h3040, 1'b1, 32'h5000);
    do_query("s0_4040", 32'h4040, 1'b1, 32'h6000);

    // Same-cycle write and query of one PC: the lookup sees the old contents.
    write_enable = 1'b1; write_source_pc = 32'h1048; write_dest_pc = 32'h7000;
    do_query("wq1048", 32'h1048, 1'b0, 32'h0);
    do_query("rq1048", 32'h1048, 1'b1, 32'h7000);
    write_enable = 1'b1; write_source_pc = 32'h1048; write_dest_pc = 32'h7700;
    do_query("wq2040", 32'h2040, 1'b1, 32'h4000);
    do_query("rq1048u", 32'h1048, 1'b1, 32'h7700);

    do_reset("rst_mid");
    do_write("wA", PC_A, 32'hA000);
    do_write("wB", PC_B, 32'hB000);
    do_write("wC", PC_C, 32'hC000);
    do_write("wD", PC_D, 32'hD000);
    do_query("hitA", PC_A, 1'b1, 32'hA000);
    do_write("wE", PC_E, 32'hE000);
`ifdef BTB_PLRU_EN
    do_query("evB", PC_B, 1'b0, 32'h0);
    do_query("keepA", PC_A, 1'b1, 32'hA000);
`else
    do_query("keepB", PC_B, 1'b1, 32'hB000);
    do_query("evA", PC_A, 1'b0, 32'h0);
`endif
    do_query("keepC", PC_C, 1'b1, 32'hC000);
    do_query("keepD", PC_D, 1'b1, 32'hD000);
    do_query("keepE", PC_E, 1'b1, 32'hE000);

    // Flush drops the same-cycle write and forces the same-cycle query to miss.
    flush = 1'b1;
    write_enable = 1'b1; write_source_pc = PC_F; write_dest_pc = 32'hF000;
    do_query("flushq", PC_C, 1'b0, 32'h0);
    do_query("fl_A", PC_A, 1'b0, 32'h0);
    do_query("fl_B", PC_B, 1'b0, 32'h0);
    do_query("fl_C", PC_C, 1'b0, 32'h0);
    do_query("fl_D", PC_D, 1'b0, 32'h0);
    do_query("fl_E", PC_E, 1'b0, 32'h0);
    do_query("fl_F", PC_F, 1'b0, 32'h0);
    do_write("wA2", PC_A, 32'hA100);
    do_query("qA2", PC_A, 1'b1, 32'hA100);

    // Reset in mid-operation discards the pending write and lookup.
    reset = 1'b0;
    write_enable = 1'b1; write_source_pc = PC_B; write_dest_pc = 32'hB100;
    query_valid = 1'b1; query_pc = PC_A;
    step("rst_op", 1'b0, 32'h0);
    last_tgt = '0;
    do_query("post_B", PC_B, 1'b0, 32'h0);
    do_query("post_A", PC_A, 1'b0, 32'h0);
    do_write("wD2", PC_D, 32'hD100);
    do_query("qD2", PC_D, 1'b1, 32'hD100);

    if (sb_q.size() != 0) check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SETS, 16, number of sets; power of two, at least 2.
REQ-002 WAYS, 4, ways per set; power of two, 1 to 8.
REQ-003 TAG_BITS, 10, stored tag width; partial tags are allowed.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-006 flush  input  1  invalidate all entries.
REQ-007 write_enable  input  1  install or update one entry.
REQ-008 write_source_pc  input  `XLEN  branch PC being written.
REQ-009 write_dest_pc  input  `XLEN  branch target being written.
REQ-010 query_valid  input  1  lookup request this cycle.
REQ-011 query_pc  input  `XLEN  PC being looked up.
REQ-012 hit  output  1  registered; the previous-cycle lookup matched a valid entry.
REQ-013 target_pc  output  `XLEN  registered; target of the matching entry.

Function
REQ-014 Address split: pc[1:0] ignored; index = pc[2 +: log2(SETS)]; tag = pc[2+log2(SETS) +: TAG_BITS].
REQ-015 Each entry holds valid, tag and a full `XLEN target.
REQ-016 Lookup latency is exactly 1 cycle: a query sampled at edge N drives hit/target_pc after edge N.
REQ-017 When query_valid=0, hit = 0 and target_pc holds its previous value the next cycle.
REQ-018 On a miss, target_pc = 0.
REQ-019 Write, tag already present in the set: overwrite that way's target; no allocation.
REQ-020 Write, tag absent: fill the lowest-numbered invalid way; if all ways are valid, replace the victim chosen by the replacement policy.
REQ-021 A query hit and every write mark the touched way most-recent.
REQ-022 Query and write in the same cycle: the lookup sees pre-write contents, with no bypass.
REQ-023 Query and write to the same set in the same cycle: the write's replacement update is applied after the query's.
REQ-024 flush: all valid bits clear at the edge; a same-cycle write is dropped and a same-cycle query returns hit=0.
REQ-025 Replacement state is not cleared by flush.
REQ-026 Priority order: reset, then flush, then write.

Reset
REQ-027 While reset=0 at an edge: all valid bits = 0, hit = 0, target_pc = 0, all replacement state = 0.
REQ-028 Reset asserted mid-operation discards any pending lookup result and write.
REQ-029 The first lookup sampled at the first edge after reset deasserts is serviced normally.

Configuration
REQ-030 Macro BTB_PLRU_EN defined: victim selection uses per-set tree pseudo-LRU (WAYS-1 bits per set), updated per REQ-021.
REQ-031 Macro BTB_PLRU_EN undefined: victim selection uses a per-set round-robin counter of log2(WAYS) bits.
  - The counter increments only when a full set allocates.
  - Hits and updates leave it unchanged.
REQ-032 With WAYS=1, both configurations behave as direct-mapped.

Structure
REQ-033 sys_defs.svh holds `BTB_SETS, `BTB_WAYS, `BTB_TAG_BITS and a packed BTB_ENTRY struct (valid, tag, target); parameter defaults derive from these.
REQ-034 Victim selection and replacement-state update live in a sub-module, btb_repl.
  - btb_repl holds state for all sets.
  - Inputs: touch set/way and allocate set.
  - Output: victim way.
  - The PLRU and round-robin variants are selected internally by BTB_PLRU_EN.

Verification (XLEN=32, SETS=16, WAYS=4, TAG_BITS=10, BTB_PLRU_EN defined)
REQ-035 Reset, then query every index 0..15 with PC = idx<<2 -> hit=0 and target_pc=0 each following cycle.
REQ-036 Write 0x0000_1040 -> 0x0000_2000, then query 0x1040 -> hit=1, target 0x2000; query 0x1044 -> hit=0.
REQ-037 Write 0x1040 -> 0x3000, then query 0x1040 -> target 0x3000, and only one way is valid in set 0.
REQ-038 Fill set 0 with tags A-D, hit A, write E -> B is evicted: B misses, A/C/D/E hit. With BTB_PLRU_EN undefined, A is evicted instead.
REQ-039 Write 0x1040 and query 0x1040 in the same cycle -> hit=0; re-query -> hit=1.
REQ-040 Flush with a same-cycle write, then query all previously written PCs -> hit=0 for every one.
